// File: rtl/modexp_pkg.sv
// Shared definitions for the modexp job arbiter: default widths, FSM
// state encoding and grant-index width helper.
package modexp_pkg;

    localparam int unsigned KEY_W_DEF   = 1024;
    localparam int unsigned NUM_REQ_DEF = 2;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LAUNCH    = 3'd1,
        WAIT_LOW  = 3'd2,
        WAIT_HIGH = 3'd3,
        RESP      = 3'd4
    } arb_state_e;

    // Width of a requester index for a given requester count.
    function automatic int unsigned grant_w(input int unsigned n);
        return $clog2(n);
    endfunction

    localparam int unsigned GRANT_W_DEF = $clog2(NUM_REQ_DEF);

endpackage

// File: rtl/modexp_job_arbiter_rr_grant.sv
// Combinational round-robin picker: scans ptr+1, ptr+2, ... (mod NUM_REQ)
// and returns the first pending requester.
module rr_grant #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned GRANT_W = 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [GRANT_W-1:0] ptr,
    output logic [GRANT_W-1:0] gnt_idx,
    output logic               gnt_any
);

    logic [31:0] idx;

    // Priority scan starting just after the last winner.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        idx     = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            idx = (32'(ptr) + k) % NUM_REQ;
            if (!gnt_any && req[idx]) begin
                gnt_any = 1'b1;
                gnt_idx = idx[GRANT_W-1:0];
            end
        end
    end

endmodule

// File: rtl/modexp_job_arbiter.sv
// Round-robin arbiter sharing one modular-exponentiation engine among
// NUM_REQ requesters. Optional statistics counters are enabled by
// defining MODEXP_ARB_STATS_EN.
module modexp_job_arbiter
    import modexp_pkg::*;
#(
    parameter int unsigned KEY_W   = KEY_W_DEF,
    parameter int unsigned NUM_REQ = NUM_REQ_DEF
) (
    input  logic                     clk_slow,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*KEY_W-1:0] req_m,
    input  logic [NUM_REQ*KEY_W-1:0] req_e,
    input  logic [NUM_REQ*KEY_W-1:0] req_n,
    output logic [NUM_REQ-1:0]       req_ack,
    output logic [NUM_REQ-1:0]       rsp_valid,
    input  logic [NUM_REQ-1:0]       rsp_ready,
    output logic [KEY_W-1:0]         rsp_data,
    output logic                     busy,
    output logic                     eng_go,
    output logic [KEY_W-1:0]         eng_m,
    output logic [KEY_W-1:0]         eng_e,
    output logic [KEY_W-1:0]         eng_n,
    input  logic [KEY_W-1:0]         eng_out,
    input  logic                     eng_finished
`ifdef MODEXP_ARB_STATS_EN
    ,
    output logic [31:0]              stat_jobs,
    output logic [31:0]              stat_busy_cycles
`endif
);

    localparam int unsigned GRANT_W = grant_w(NUM_REQ);

    arb_state_e           state_q, state_d;
    logic [GRANT_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [GRANT_W-1:0]   gnt_q, gnt_d;
    logic [KEY_W-1:0]     eng_m_q, eng_m_d;
    logic [KEY_W-1:0]     eng_e_q, eng_e_d;
    logic [KEY_W-1:0]     eng_n_q, eng_n_d;
    logic [NUM_REQ-1:0]   req_ack_q, req_ack_d;
    logic [NUM_REQ-1:0]   rsp_valid_q, rsp_valid_d;
    logic [KEY_W-1:0]     rsp_data_q, rsp_data_d;
    logic                 eng_go_q, eng_go_d;
    logic [GRANT_W-1:0]   pick_idx;
    logic                 pick_any;

    rr_grant #(
        .NUM_REQ (NUM_REQ),
        .GRANT_W (GRANT_W)
    ) u_rr_grant (
        .req     (req_valid),
        .ptr     (rr_ptr_q),
        .gnt_idx (pick_idx),
        .gnt_any (pick_any)
    );

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk_slow) begin
        if (!reset) begin
            state_q     <= IDLE;
            rr_ptr_q    <= GRANT_W'(NUM_REQ - 1);
            gnt_q       <= '0;
            eng_m_q     <= '0;
            eng_e_q     <= '0;
            eng_n_q     <= '0;
            req_ack_q   <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            eng_go_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            gnt_q       <= gnt_d;
            eng_m_q     <= eng_m_d;
            eng_e_q     <= eng_e_d;
            eng_n_q     <= eng_n_d;
            req_ack_q   <= req_ack_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            eng_go_q    <= eng_go_d;
        end
    end

    // Next-state logic: grant, launch engine, track finished, hand back result.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        gnt_d       = gnt_q;
        eng_m_d     = eng_m_q;
        eng_e_d     = eng_e_q;
        eng_n_d     = eng_n_q;
        req_ack_d   = '0;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        eng_go_d    = eng_go_q;
        case (state_q)
            IDLE: begin
                if (pick_any && eng_finished) begin
                    gnt_d              = pick_idx;
                    rr_ptr_d           = pick_idx;
                    eng_m_d            = req_m[32'(pick_idx) * KEY_W +: KEY_W];
                    eng_e_d            = req_e[32'(pick_idx) * KEY_W +: KEY_W];
                    eng_n_d            = req_n[32'(pick_idx) * KEY_W +: KEY_W];
                    req_ack_d[pick_idx] = 1'b1;
                    eng_go_d           = 1'b1;
                    state_d            = LAUNCH;
                end
            end
            LAUNCH: begin
                state_d = WAIT_LOW;
            end
            WAIT_LOW: begin
                if (!eng_finished) begin
                    eng_go_d = 1'b0;
                    state_d  = WAIT_HIGH;
                end
            end
            WAIT_HIGH: begin
                if (eng_finished) begin
                    rsp_data_d         = eng_out;
                    rsp_valid_d[gnt_q] = 1'b1;
                    state_d            = RESP;
                end
            end
            RESP: begin
                if (rsp_ready[gnt_q]) begin
                    rsp_valid_d = '0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign req_ack   = req_ack_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign busy      = (state_q != IDLE);
    assign eng_go    = eng_go_q;
    assign eng_m     = eng_m_q;
    assign eng_e     = eng_e_q;
    assign eng_n     = eng_n_q;

`ifdef MODEXP_ARB_STATS_EN
    logic [31:0] stat_jobs_q, stat_jobs_d;
    logic [31:0] stat_busy_q, stat_busy_d;

    // Saturating job and busy-cycle counters.
    always_comb begin
        stat_jobs_d = stat_jobs_q;
        stat_busy_d = stat_busy_q;
        if (state_q == RESP && state_d == IDLE && stat_jobs_q != '1)
            stat_jobs_d = stat_jobs_q + 32'd1;
        if (busy && stat_busy_q != '1)
            stat_busy_d = stat_busy_q + 32'd1;
    end

    // Counter registers.
    always_ff @(posedge clk_slow) begin
        if (!reset) begin
            stat_jobs_q <= '0;
            stat_busy_q <= '0;
        end else begin
            stat_jobs_q <= stat_jobs_d;
            stat_busy_q <= stat_busy_d;
        end
    end

    assign stat_jobs        = stat_jobs_q;
    assign stat_busy_cycles = stat_busy_q;
`endif

endmodule

// File: tb/tb_modexp_job_arbiter.sv
// Directed testbench for modexp_job_arbiter with a behavioural engine model
// (random 5..40 cycle latency, finished drops 2 cycles after go rises).
module tb_modexp_job_arbiter;

    localparam int unsigned KEY_W   = 1024;
    localparam int unsigned NUM_REQ = 2;

    logic                     clk_slow = 1'b0;
    logic                     reset    = 1'b0;
    logic [NUM_REQ-1:0]       req_valid = '0;
    logic [NUM_REQ*KEY_W-1:0] req_m = '0, req_e = '0, req_n = '0;
    logic [NUM_REQ-1:0]       req_ack, rsp_valid;
    logic [NUM_REQ-1:0]       rsp_ready = '0;
    logic [KEY_W-1:0]         rsp_data;
    logic                     busy, eng_go;
    logic [KEY_W-1:0]         eng_m, eng_e, eng_n;
    logic [KEY_W-1:0]         eng_out = '0;
    logic                     eng_finished = 1'b1;
`ifdef MODEXP_ARB_STATS_EN
    logic [31:0]              stat_jobs, stat_busy_cycles;
`endif

    int errors = 0;
    int checks = 0;
    int busy_cnt = 0;

    always #5 clk_slow = ~clk_slow;

    modexp_job_arbiter #(.KEY_W(KEY_W), .NUM_REQ(NUM_REQ)) dut (
        .clk_slow     (clk_slow),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_m        (req_m),
        .req_e        (req_e),
        .req_n        (req_n),
        .req_ack      (req_ack),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_data     (rsp_data),
        .busy         (busy),
        .eng_go       (eng_go),
        .eng_m        (eng_m),
        .eng_e        (eng_e),
        .eng_n        (eng_n),
        .eng_out      (eng_out),
        .eng_finished (eng_finished)
`ifdef MODEXP_ARB_STATS_EN
        ,
        .stat_jobs        (stat_jobs),
        .stat_busy_cycles (stat_busy_cycles)
`endif
    );

    // Behavioural engine: small operands only (low 32 bits).
    function automatic logic [31:0] pw(input logic [31:0] b, input logic [31:0] e, input logic [31:0] n);
        longint unsigned r, bb, ee, nn;
        nn = 64'(n);
        r  = 1 % nn;
        bb = 64'(b) % nn;
        ee = 64'(e);
        while (ee != 0) begin
            if (ee[0]) r = (r * bb) % nn;
            bb = (bb * bb) % nn;
            ee = ee >> 1;
        end
        return r[31:0];
    endfunction

    logic go_prev = 1'b0;
    int   eng_st  = 0;
    int   eng_cnt = 0;

    always @(posedge clk_slow) begin
        if (!reset) begin
            eng_finished <= 1'b1;
            eng_out      <= '0;
            go_prev      <= 1'b0;
            eng_st       <= 0;
            eng_cnt      <= 0;
        end else begin
            go_prev <= eng_go;
            case (eng_st)
                0: if (eng_go && !go_prev) eng_st <= 1;
                1: begin
                    eng_finished <= 1'b0;
                    eng_cnt      <= int'($urandom_range(40, 5));
                    eng_st       <= 2;
                end
                default: begin
                    if (eng_cnt <= 1) begin
                        eng_out      <= {{(KEY_W-32){1'b0}}, pw(eng_m[31:0], eng_e[31:0], eng_n[31:0])};
                        eng_finished <= 1'b1;
                        eng_st       <= 0;
                    end else begin
                        eng_cnt <= eng_cnt - 1;
                    end
                end
            endcase
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        if (!reset) busy_cnt = 0;
        else if (busy) busy_cnt++;
        @(posedge clk_slow);
        #1;
    endtask

    task automatic chk(input string name, input logic [KEY_W-1:0] act, input logic [KEY_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic set_ops(input int r, input logic [31:0] m, input logic [31:0] e, input logic [31:0] n);
        req_m[r*KEY_W +: KEY_W] = {{(KEY_W-32){1'b0}}, m};
        req_e[r*KEY_W +: KEY_W] = {{(KEY_W-32){1'b0}}, e};
        req_n[r*KEY_W +: KEY_W] = {{(KEY_W-32){1'b0}}, n};
    endtask

    task automatic wait_ack(input int idx, input bit drop, input bit chk_lat);
        int n = 0;
        do begin
            tick();
            n++;
        end while (req_ack == '0 && n < 20);
        chk("ack_idx", KEY_W'(req_ack), KEY_W'(1 << idx));
        if (chk_lat) chk("ack_latency", KEY_W'(n), KEY_W'(1));
        if (drop) req_valid[idx] = 1'b0;
    endtask

    task automatic wait_rsp(input int idx, input logic [31:0] exp, input bit do_hs);
        int n = 0;
        int acks = 0;
        while (rsp_valid == '0 && n < 200) begin
            tick();
            n++;
            if (req_ack != '0) acks++;
        end
        chk("rsp_valid_idx", KEY_W'(rsp_valid), KEY_W'(1 << idx));
        chk("rsp_data", rsp_data, KEY_W'(exp));
        chk("no_ack_in_job", KEY_W'(acks), KEY_W'(0));
        if (do_hs) begin
            rsp_ready[idx] = 1'b1;
            tick();
            chk("rsp_valid_clear", KEY_W'(rsp_valid), KEY_W'(0));
            rsp_ready[idx] = 1'b0;
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        req_valid = '0;
        rsp_ready = '0;
        repeat (3) tick();
        reset = 1'b1;
        tick();
    endtask

    typedef struct {
        int          r;
        logic [31:0] m;
        logic [31:0] e;
        logic [31:0] n;
        logic [31:0] exp;
    } vec_t;

    vec_t vt[6];

    initial begin
        int bad;
        vt[0] = '{0, 32'd4,  32'd13, 32'd497,  32'd445};
        vt[1] = '{1, 32'd2,  32'd10, 32'd1000, 32'd24};
        vt[2] = '{0, 32'd3,  32'd5,  32'd7,    32'd5};
        vt[3] = '{1, 32'd5,  32'd0,  32'd13,   32'd1};
        vt[4] = '{0, 32'd7,  32'd2,  32'd10,   32'd9};
        vt[5] = '{1, 32'd10, 32'd3,  32'd11,   32'd10};

        // Reset state
        repeat (3) tick();
        chk("rst_req_ack", KEY_W'(req_ack), '0);
        chk("rst_rsp_valid", KEY_W'(rsp_valid), '0);
        chk("rst_rsp_data", rsp_data, '0);
        chk("rst_busy", KEY_W'(busy), '0);
        chk("rst_eng_go", KEY_W'(eng_go), '0);
        chk("rst_eng_m", eng_m, '0);
        chk("rst_eng_n", eng_n, '0);
        reset = 1'b1;
        tick();

        // Single jobs from the vector table
        for (int i = 0; i < 6; i++) begin
            set_ops(vt[i].r, vt[i].m, vt[i].e, vt[i].n);
            req_valid[vt[i].r] = 1'b1;
            wait_ack(vt[i].r, 1'b1, 1'b1);
            chk("eng_m_latched", eng_m, KEY_W'(vt[i].m));
            wait_rsp(vt[i].r, vt[i].exp, 1'b1);
        end

        // Simultaneous requests out of reset: req0 first, then req1
        do_reset();
        set_ops(0, 32'd2, 32'd10, 32'd1000);
        set_ops(1, 32'd3, 32'd5, 32'd7);
        req_valid = 2'b11;
        wait_ack(0, 1'b1, 1'b1);
        wait_rsp(0, 32'd24, 1'b1);
        wait_ack(1, 1'b1, 1'b1);
        wait_rsp(1, 32'd5, 1'b1);

        // Fairness: both held for six jobs
        req_valid = 2'b11;
        for (int k = 0; k < 6; k++) begin
            wait_ack(k % 2, 1'b0, 1'b0);
            wait_rsp(k % 2, (k % 2 == 1) ? 32'd5 : 32'd24, 1'b1);
        end
        req_valid = '0;
        tick();

        // Backpressure: result held 20 cycles, non-granted ready ignored
        set_ops(0, 32'd4, 32'd13, 32'd497);
        req_valid[0] = 1'b1;
        wait_ack(0, 1'b1, 1'b0);
        set_ops(1, 32'd7, 32'd2, 32'd10);
        req_valid[1] = 1'b1;
        wait_rsp(0, 32'd445, 1'b0);
        rsp_ready[1] = 1'b1;
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (rsp_valid != 2'b01 || rsp_data != KEY_W'(445) || req_ack != '0) bad++;
        end
        chk("bp_stable", KEY_W'(bad), '0);
        rsp_ready = 2'b01;
        tick();
        chk("bp_release", KEY_W'(rsp_valid), '0);
        rsp_ready = '0;
        wait_ack(1, 1'b1, 1'b1);
        wait_rsp(1, 32'd9, 1'b1);

        // Reset during WAIT_HIGH
        set_ops(0, 32'd4, 32'd13, 32'd497);
        req_valid[0] = 1'b1;
        wait_ack(0, 1'b1, 1'b0);
        bad = 0;
        while (eng_go && bad < 20) begin
            tick();
            bad++;
        end
        chk("mid_wait_high_go", KEY_W'(eng_go), '0);
        chk("mid_wait_high_busy", KEY_W'(busy), KEY_W'(1));
        reset = 1'b0;
        tick();
        chk("abort_busy", KEY_W'(busy), '0);
        chk("abort_rsp_valid", KEY_W'(rsp_valid), '0);
        chk("abort_rsp_data", rsp_data, '0);
        chk("abort_eng_go", KEY_W'(eng_go), '0);
        chk("abort_eng_m", eng_m, '0);
        reset = 1'b1;
        bad = 0;
        for (int c = 0; c < 50; c++) begin
            tick();
            if (rsp_valid != '0 || busy) bad++;
        end
        chk("abort_no_rsp", KEY_W'(bad), '0);
        req_valid[0] = 1'b1;
        wait_ack(0, 1'b1, 1'b1);
        wait_rsp(0, 32'd445, 1'b1);

`ifdef MODEXP_ARB_STATS_EN
        do_reset();
        chk("stat_jobs_rst", KEY_W'(stat_jobs), '0);
        for (int i = 0; i < 3; i++) begin
            set_ops(vt[i].r, vt[i].m, vt[i].e, vt[i].n);
            req_valid[vt[i].r] = 1'b1;
            wait_ack(vt[i].r, 1'b1, 1'b0);
            wait_rsp(vt[i].r, vt[i].exp, 1'b1);
        end
        tick();
        chk("stat_jobs", KEY_W'(stat_jobs), KEY_W'(3));
        chk("stat_busy_cycles", KEY_W'(stat_busy_cycles), KEY_W'(busy_cnt));
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
